// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receive framer.
//   UART_DATA_BITS_MAX : widest supported data field
//   uart_st_e          : receive FSM state encodings (3-bit)
package uart_rx_pkg;

    localparam int UART_DATA_BITS_MAX = 8;

    typedef enum logic [2:0] {
        UART_ST_IDLE   = 3'd0,
        UART_ST_START  = 3'd1,
        UART_ST_DATA   = 3'd2,
        UART_ST_PARITY = 3'd3,
        UART_ST_STOP   = 3'd4
    } uart_st_e;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchroniser for the serial input plus falling-edge detect.
//   clk26m   in  function clock
//   rst26m_  in  async active-low reset; all flops preset to 1 (idle line)
//   i_rxd    in  raw serial input, asynchronous to clk26m
//   o_rxd_s  out synchronised serial input
//   o_fall   out high while the synchronised line has just gone 1 -> 0
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk26m,
    input  logic rst26m_,
    input  logic i_rxd,
    output logic o_rxd_s,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_d1;

    always_ff @(posedge clk26m or negedge rst26m_) begin
        if (!rst26m_) begin
            r_sync   <= '1;
            r_rxd_d1 <= 1'b1;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_rxd};
            r_rxd_d1 <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rxd_s = r_sync[SYNC_STAGES-1];
    // Edge compares the registered previous value with the current synchronised
    // value, so the FSM sees it one clock after the synchroniser output drops.
    assign o_fall  = r_rxd_d1 & ~o_rxd_s;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receive framer.
// Synchronises uart_rxd, detects the start bit, enables the baud generator,
// samples each bit on the rx_bpsclk mid-bit pulse and presents the byte with
// parity/frame error flags on a valid/ready interface.
//   clk26m         in  function clock
//   rst26m_        in  async active-low reset
//   uart_rxd       in  serial input, idle high
//   rx_bpsclk      in  mid-bit sample pulse from the baud generator
//   parity_en      in  frame carries a parity bit
//   parity_odd     in  odd (1) / even (0) parity
//   rx_ready       in  consumer accepts the held byte
//   rx_bps_en      out baud counter enable
//   rx_data        out received byte, right-aligned
//   rx_valid       out rx_data and flags valid
//   rx_parity_err  out parity mismatch for the held byte
//   rx_frame_err   out stop bit sampled low for the held byte
//   rx_overrun     out 1-cycle pulse: completed frame dropped
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk26m,
    input  logic                 rst26m_,
    input  logic                 uart_rxd,
    input  logic                 rx_bpsclk,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    output logic                 rx_bps_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 w_rxd_s;
    logic                 w_fall;
    logic                 w_done;
    uart_st_e             r_state;
    uart_st_e             w_state_nxt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_perr;
    logic                 r_bps_en;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr_out;
    logic                 r_ferr_out;
    logic                 r_overrun;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk26m  (clk26m),
        .rst26m_ (rst26m_),
        .i_rxd   (uart_rxd),
        .o_rxd_s (w_rxd_s),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk26m or negedge rst26m_) begin
        if (!rst26m_) r_state <= UART_ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            UART_ST_IDLE:   if (w_fall) w_state_nxt = UART_ST_START;
            // A start bit that is high again at mid-bit was a glitch.
            UART_ST_START:  if (rx_bpsclk) w_state_nxt = w_rxd_s ? UART_ST_IDLE : UART_ST_DATA;
            UART_ST_DATA:   if (rx_bpsclk && r_bit_cnt == LAST_BIT)
                                w_state_nxt = r_par_en ? UART_ST_PARITY : UART_ST_STOP;
            UART_ST_PARITY: if (rx_bpsclk) w_state_nxt = UART_ST_STOP;
            // Returning to IDLE at mid-stop-bit lets a back-to-back start edge be caught.
            UART_ST_STOP:   if (rx_bpsclk) w_state_nxt = UART_ST_IDLE;
            default:        w_state_nxt = UART_ST_IDLE;
        endcase
    end

    assign w_done = (r_state == UART_ST_STOP) && rx_bpsclk;

    // Frame datapath: bit counter, shift register, parity result.
    always_ff @(posedge clk26m or negedge rst26m_) begin
        if (!rst26m_) begin
            r_bps_en  <= 1'b0;
            r_bit_cnt <= 3'd0;
            r_shreg   <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_bps_en <= (w_state_nxt != UART_ST_IDLE);
            if (r_state == UART_ST_IDLE && w_fall) begin
                // Parity mode is frozen for the whole frame.
                r_par_en  <= parity_en;
                r_par_odd <= parity_odd;
                r_perr    <= 1'b0;
            end
            if (rx_bpsclk) begin
                case (r_state)
                    UART_ST_START:  r_bit_cnt <= 3'd0;
                    UART_ST_DATA: begin
                        r_shreg   <= {w_rxd_s, r_shreg[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    UART_ST_PARITY: r_perr <= ^{r_shreg, w_rxd_s} ^ r_par_odd;
                    default: ;
                endcase
            end
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge clk26m or negedge rst26m_) begin
        if (!rst26m_) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (!r_valid || rx_ready) begin
                    r_data     <= r_shreg;
                    r_perr_out <= r_perr;
                    r_ferr_out <= ~w_rxd_s;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_bps_en     = r_bps_en;
    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign rx_parity_err = r_perr_out;
    assign rx_frame_err  = r_ferr_out;
    assign rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int BIT_CLKS = 17;

    logic       clk26m = 1'b0;
    logic       rst26m_;
    logic       uart_rxd;
    logic       rx_bpsclk;
    logic       parity_en;
    logic       parity_odd;
    logic       rx_ready;
    logic       rx_bps_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;

    int checks = 0;
    int errors = 0;

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk26m        (clk26m),
        .rst26m_       (rst26m_),
        .uart_rxd      (uart_rxd),
        .rx_bpsclk     (rx_bpsclk),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .rx_ready      (rx_ready),
        .rx_bps_en     (rx_bps_en),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk26m = ~clk26m;

    // Baud generator stand-in: baud_div=0 -> 17-clk bit, pulse at count 8.
    logic [4:0] bcnt;
    always @(posedge clk26m or negedge rst26m_) begin
        if (!rst26m_) begin
            bcnt      <= 5'd0;
            rx_bpsclk <= 1'b0;
        end else if (!rx_bps_en) begin
            bcnt      <= 5'd0;
            rx_bpsclk <= 1'b0;
        end else begin
            rx_bpsclk <= (bcnt == 5'd7);
            bcnt      <= (bcnt == 5'd16) ? 5'd0 : bcnt + 5'd1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Drives start, data and optional parity; leaves the stop level on the line
    // at the start of the stop bit. Also checks start-edge to rx_bps_en latency (3 clks).
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic stop);
        uart_rxd = 1'b0;
        repeat (2) @(negedge clk26m);
        chk("bps_en_pre", 32'(rx_bps_en), 32'd0);
        @(negedge clk26m);
        chk("bps_en_rise", 32'(rx_bps_en), 32'd1);
        repeat (BIT_CLKS - 3) @(negedge clk26m);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk26m);
        end
        if (pe) begin
            uart_rxd = pb;
            repeat (BIT_CLKS) @(negedge clk26m);
        end
        uart_rxd = stop;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (rx_valid !== 1'b1 && n < BIT_CLKS - 1) begin
            @(negedge clk26m);
            n++;
        end
        chk("valid_rise", 32'(rx_valid), 32'd1);
    endtask

    // Full frame with rx_ready=1: byte and flags, 1-cycle valid, baud enable off.
    task automatic rx_frame_check(input logic [7:0] d, input logic pe, input logic po, input logic pb,
                                  input logic exp_perr, input logic exp_ferr, input logic stop);
        int n;
        parity_en  = pe;
        parity_odd = po;
        send_frame(d, pe, pb, stop);
        wait_valid(n);
        chk("rx_data",  32'(rx_data), 32'(d));
        chk("perr",     32'(rx_parity_err), 32'(exp_perr));
        chk("ferr",     32'(rx_frame_err), 32'(exp_ferr));
        chk("bps_en_off", 32'(rx_bps_en), 32'd0);
        @(negedge clk26m);
        chk("valid_1clk", 32'(rx_valid), 32'd0);
        repeat (BIT_CLKS - 1 - n) @(negedge clk26m);
    endtask

    initial begin
        int n;
        int seen;
        int cnt;
        uart_rxd   = 1'b1;
        rst26m_    = 1'b0;
        rx_ready   = 1'b1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        repeat (3) @(negedge clk26m);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data",  32'(rx_data), 32'd0);
        chk("rst_bps_en", 32'(rx_bps_en), 32'd0);
        chk("rst_perr",  32'(rx_parity_err), 32'd0);
        chk("rst_ferr",  32'(rx_frame_err), 32'd0);
        chk("rst_ovr",   32'(rx_overrun), 32'd0);
        rst26m_ = 1'b1;
        repeat (5) @(negedge clk26m);

        // T1: 8N1 0xA5
        rx_frame_check(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk26m);

        // T2: parity. 0x3C has four ones.
        rx_frame_check(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        rx_frame_check(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rx_frame_check(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        repeat (5) @(negedge clk26m);

        // T3: 4-clk glitch low
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk26m);
        uart_rxd = 1'b1;
        seen = 0;
        cnt  = 0;
        repeat (30) begin
            @(negedge clk26m);
            if (rx_bps_en) seen++;
            if (rx_valid) cnt++;
        end
        chk("glitch_en_pulsed", 32'(seen > 0), 32'd1);
        chk("glitch_en_short", 32'(seen < 14), 32'd1);
        chk("glitch_no_valid", 32'(cnt), 32'd0);
        chk("glitch_idle", 32'(rx_bps_en), 32'd0);

        // T4: 0x00 with stop low, line held low, then released
        rx_frame_check(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        seen = 0;
        repeat (20) begin
            @(negedge clk26m);
            if (rx_bps_en) seen++;
        end
        chk("low_line_idle", 32'(seen), 32'd0);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk26m);
        rx_frame_check(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk26m);

        // T5: overrun with rx_ready=0, back-to-back
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        wait_valid(n);
        chk("ovr_first", 32'(rx_data), 32'h11);
        repeat (BIT_CLKS - n) @(negedge clk26m);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        repeat (BIT_CLKS) begin
            @(negedge clk26m);
            if (rx_overrun) cnt++;
        end
        chk("ovr_pulses", 32'(cnt), 32'd1);
        chk("ovr_held_data", 32'(rx_data), 32'h11);
        chk("ovr_held_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk26m);
        chk("ovr_drain", 32'(rx_valid), 32'd0);
        repeat (5) @(negedge clk26m);

        // T6: held byte present, then reset mid DATA bit 4 of 0xF0
        rx_ready = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        wait_valid(n);
        chk("pre_rst_data", 32'(rx_data), 32'hC3);
        repeat (BIT_CLKS - n) @(negedge clk26m);
        uart_rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk26m);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = 1'b0;
            repeat (BIT_CLKS) @(negedge clk26m);
        end
        uart_rxd = 1'b1;
        repeat (8) @(negedge clk26m);
        chk("mid_frame_en", 32'(rx_bps_en), 32'd1);
        #2 rst26m_ = 1'b0;
        #1;
        chk("arst_valid", 32'(rx_valid), 32'd0);
        chk("arst_data",  32'(rx_data), 32'd0);
        chk("arst_bps_en", 32'(rx_bps_en), 32'd0);
        chk("arst_ovr",   32'(rx_overrun), 32'd0);
        @(negedge clk26m);
        repeat (3) @(negedge clk26m);
        rst26m_  = 1'b1;
        rx_ready = 1'b1;
        repeat (5) @(negedge clk26m);
        chk("post_rst_valid", 32'(rx_valid), 32'd0);
        rx_frame_check(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
